// File: rtl/exec_dep_tracker_pkg.sv
// Shared sizing constants and the per-slot event bundle for the execution dependency tracker.
// Wavefront count and wfid width are global; the VCC counter width default belongs to issue.
package exec_dep_tracker_pkg;

    localparam int GLB_NUM_WF    = 40;
    localparam int GLB_WFID_W    = 6;
    localparam int ISS_VCC_CNT_W = 3;

    typedef struct packed {
        logic inc_vcc;
        logic dec_salu_vcc;
        logic dec_valu_vcc;
        logic set_exec;
        logic set_m0;
        logic set_scc;
        logic clr_exec;
        logic clr_m0;
        logic clr_scc;
    } dep_evt_t;

    function automatic logic wfid_oob(input logic [GLB_WFID_W-1:0] id, input int num_wf);
        return {{(32-GLB_WFID_W){1'b0}}, id} >= $unsigned(num_wf);
    endfunction

endpackage

// File: rtl/exec_dep_tracker_dep_slot.sv
// One wavefront slot: saturating VCC write counter plus EXEC/M0/SCC pending flags.
// Optional o_err (EXEC_DEP_TRACKER_ERR_EN) reports underflow or clearing an already-clear flag.
module dep_slot
    import exec_dep_tracker_pkg::*;
#(
    parameter int CNT_W = ISS_VCC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_init,
    input  dep_evt_t         i_evt,
    output logic [CNT_W-1:0] o_vcc_cnt,
    output logic             o_exec,
    output logic             o_m0,
    output logic             o_scc
`ifdef EXEC_DEP_TRACKER_ERR_EN
    ,
    output logic             o_err
`endif
);

    logic [CNT_W-1:0] r_vcc_cnt;
    logic             r_exec;
    logic             r_m0;
    logic             r_scc;

    logic [CNT_W:0]   w_sum;
    logic [1:0]       w_dec;
    logic [CNT_W-1:0] w_vcc_next;

    // Net delta of one possible increment and up to two decrements, floored at zero.
    always_comb begin
        w_sum      = {1'b0, r_vcc_cnt} + (CNT_W+1)'(i_evt.inc_vcc);
        w_dec      = {1'b0, i_evt.dec_salu_vcc} + {1'b0, i_evt.dec_valu_vcc};
        w_vcc_next = '0;
        if (w_sum >= (CNT_W+1)'(w_dec))
            w_vcc_next = CNT_W'(w_sum - (CNT_W+1)'(w_dec));
    end

    // NOTE: state uses non-blocking assignments so every slot samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_init) begin
            r_vcc_cnt <= '0;
            r_exec    <= 1'b0;
            r_m0      <= 1'b0;
            r_scc     <= 1'b0;
        end else begin
            r_vcc_cnt <= w_vcc_next;
            r_exec    <= i_evt.set_exec | (r_exec & ~i_evt.clr_exec);
            r_m0      <= i_evt.set_m0   | (r_m0   & ~i_evt.clr_m0);
            r_scc     <= i_evt.set_scc  | (r_scc  & ~i_evt.clr_scc);
        end
    end

    assign o_vcc_cnt = r_vcc_cnt;
    assign o_exec    = r_exec;
    assign o_m0      = r_m0;
    assign o_scc     = r_scc;

`ifdef EXEC_DEP_TRACKER_ERR_EN
    assign o_err = (w_sum < (CNT_W+1)'(w_dec))
                 | (i_evt.clr_exec & ~r_exec)
                 | (i_evt.clr_m0   & ~r_m0)
                 | (i_evt.clr_scc  & ~r_scc);
`endif

endmodule

// File: rtl/exec_dep_tracker.sv
// Tracks outstanding VCC/EXEC/M0/SCC writes per wavefront for issue-stage hazard checks.
// Define EXEC_DEP_TRACKER_ERR_EN to build the sticky dep_err protocol checker.
module exec_dep_tracker
    import exec_dep_tracker_pkg::*;
#(
    parameter int NUM_WF    = GLB_NUM_WF,
    parameter int VCC_CNT_W = ISS_VCC_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [GLB_WFID_W-1:0] issue_wfid,
    input  logic                  issue_wr_vcc,
    input  logic                  issue_wr_exec,
    input  logic                  issue_wr_m0,
    input  logic                  issue_wr_scc,
    input  logic                  issue_valu,
    input  logic [GLB_WFID_W-1:0] salu_wr_wfid,
    input  logic                  issue_salu_wr_vcc_en,
    input  logic                  issue_salu_wr_exec_en,
    input  logic                  issue_salu_wr_m0_en,
    input  logic                  issue_salu_wr_scc_en,
    input  logic                  issue_valu_wr_vcc_en,
    input  logic [GLB_WFID_W-1:0] issue_valu_wr_vcc_wfid,
    input  logic                  fetch_init_wf_en,
    input  logic [GLB_WFID_W-1:0] fetch_init_wf_id,
    output logic [NUM_WF-1:0]     vcc_pending,
    output logic [NUM_WF-1:0]     exec_pending,
    output logic [NUM_WF-1:0]     m0_pending,
    output logic [NUM_WF-1:0]     scc_pending,
    output logic                  dep_err
);

    logic              w_accept;
    logic [NUM_WF-1:0] w_sat;
    logic [NUM_WF-1:0] w_iss_sel;
    logic              w_unused_valu;
`ifdef EXEC_DEP_TRACKER_ERR_EN
    logic [NUM_WF-1:0] w_slot_err;
`endif

    // One counter covers both retire paths, so the VCC write source is not needed here.
    assign w_unused_valu = issue_valu;

    assign issue_ready = !(issue_wr_vcc && |(w_sat & w_iss_sel));
    assign w_accept    = issue_valid && issue_ready;

    for (genvar w = 0; w < NUM_WF; w++) begin : g_slot
        localparam logic [GLB_WFID_W-1:0] ID = GLB_WFID_W'(w);

        logic                 w_iss_hit;
        logic                 w_salu_hit;
        logic                 w_valu_hit;
        logic                 w_init_hit;
        dep_evt_t             w_evt;
        logic [VCC_CNT_W-1:0] w_cnt;

        // Out-of-range wfids never equal a slot index, so they drop out here.
        assign w_iss_hit  = w_accept && (issue_wfid == ID);
        assign w_salu_hit = (salu_wr_wfid == ID);
        assign w_valu_hit = issue_valu_wr_vcc_en && (issue_valu_wr_vcc_wfid == ID);
        assign w_init_hit = fetch_init_wf_en && (fetch_init_wf_id == ID);

        assign w_evt = '{
            inc_vcc:      w_iss_hit && issue_wr_vcc,
            dec_salu_vcc: w_salu_hit && issue_salu_wr_vcc_en,
            dec_valu_vcc: w_valu_hit,
            set_exec:     w_iss_hit && issue_wr_exec,
            set_m0:       w_iss_hit && issue_wr_m0,
            set_scc:      w_iss_hit && issue_wr_scc,
            clr_exec:     w_salu_hit && issue_salu_wr_exec_en,
            clr_m0:       w_salu_hit && issue_salu_wr_m0_en,
            clr_scc:      w_salu_hit && issue_salu_wr_scc_en
        };

        dep_slot #(
            .CNT_W (VCC_CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_init    (w_init_hit),
            .i_evt     (w_evt),
            .o_vcc_cnt (w_cnt),
            .o_exec    (exec_pending[w]),
            .o_m0      (m0_pending[w]),
            .o_scc     (scc_pending[w])
`ifdef EXEC_DEP_TRACKER_ERR_EN
            ,
            .o_err     (w_slot_err[w])
`endif
        );

        assign vcc_pending[w] = |w_cnt;
        assign w_sat[w]       = &w_cnt;
        assign w_iss_sel[w]   = (issue_wfid == ID);
    end

`ifdef EXEC_DEP_TRACKER_ERR_EN
    logic r_dep_err;
    logic w_oob;

    assign w_oob = (w_accept && wfid_oob(issue_wfid, NUM_WF))
                || ((issue_salu_wr_vcc_en || issue_salu_wr_exec_en ||
                     issue_salu_wr_m0_en  || issue_salu_wr_scc_en) &&
                    wfid_oob(salu_wr_wfid, NUM_WF))
                || (issue_valu_wr_vcc_en && wfid_oob(issue_valu_wr_vcc_wfid, NUM_WF))
                || (fetch_init_wf_en && wfid_oob(fetch_init_wf_id, NUM_WF));

    always_ff @(posedge clk) begin
        if (rst)
            r_dep_err <= 1'b0;
        else if (w_oob || (|w_slot_err))
            r_dep_err <= 1'b1;
    end

    assign dep_err = r_dep_err;
`else
    assign dep_err = 1'b0;
`endif

endmodule

// File: tb/tb_exec_dep_tracker.sv
// Directed self-checking bench for exec_dep_tracker; dep_err expectation follows
// whether EXEC_DEP_TRACKER_ERR_EN is defined for the build.
module tb_exec_dep_tracker;

    localparam int NUM_WF = 40;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic              issue_ready;
    logic [5:0]        issue_wfid;
    logic              issue_wr_vcc, issue_wr_exec, issue_wr_m0, issue_wr_scc;
    logic              issue_valu;
    logic [5:0]        salu_wr_wfid;
    logic              issue_salu_wr_vcc_en, issue_salu_wr_exec_en;
    logic              issue_salu_wr_m0_en, issue_salu_wr_scc_en;
    logic              issue_valu_wr_vcc_en;
    logic [5:0]        issue_valu_wr_vcc_wfid;
    logic              fetch_init_wf_en;
    logic [5:0]        fetch_init_wf_id;
    logic [NUM_WF-1:0] vcc_pending, exec_pending, m0_pending, scc_pending;
    logic              dep_err;

    int                n_chk  = 0;
    int                n_pass = 0;
    logic [NUM_WF-1:0] e;
    logic              exp_err;

    exec_dep_tracker dut (
        .clk                    (clk),
        .rst                    (rst),
        .issue_valid            (issue_valid),
        .issue_ready            (issue_ready),
        .issue_wfid             (issue_wfid),
        .issue_wr_vcc           (issue_wr_vcc),
        .issue_wr_exec          (issue_wr_exec),
        .issue_wr_m0            (issue_wr_m0),
        .issue_wr_scc           (issue_wr_scc),
        .issue_valu             (issue_valu),
        .salu_wr_wfid           (salu_wr_wfid),
        .issue_salu_wr_vcc_en   (issue_salu_wr_vcc_en),
        .issue_salu_wr_exec_en  (issue_salu_wr_exec_en),
        .issue_salu_wr_m0_en    (issue_salu_wr_m0_en),
        .issue_salu_wr_scc_en   (issue_salu_wr_scc_en),
        .issue_valu_wr_vcc_en   (issue_valu_wr_vcc_en),
        .issue_valu_wr_vcc_wfid (issue_valu_wr_vcc_wfid),
        .fetch_init_wf_en       (fetch_init_wf_en),
        .fetch_init_wf_id       (fetch_init_wf_id),
        .vcc_pending            (vcc_pending),
        .exec_pending           (exec_pending),
        .m0_pending             (m0_pending),
        .scc_pending            (scc_pending),
        .dep_err                (dep_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        rst = 1'b0;
        issue_valid = 1'b0; issue_wfid = '0;
        issue_wr_vcc = 1'b0; issue_wr_exec = 1'b0; issue_wr_m0 = 1'b0; issue_wr_scc = 1'b0;
        issue_valu = 1'b0;
        salu_wr_wfid = '0;
        issue_salu_wr_vcc_en = 1'b0; issue_salu_wr_exec_en = 1'b0;
        issue_salu_wr_m0_en = 1'b0; issue_salu_wr_scc_en = 1'b0;
        issue_valu_wr_vcc_en = 1'b0; issue_valu_wr_vcc_wfid = '0;
        fetch_init_wf_en = 1'b0; fetch_init_wf_id = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        issue_valid = 1'b1; issue_wfid = 6'd1; issue_wr_vcc = 1'b1; issue_wr_exec = 1'b1;
        step();
        idle();
        e = '0;
        n_chk++; if (vcc_pending !== e) $display("FAIL reset_vcc: got %h want %h", vcc_pending, e); else n_pass++;
        n_chk++; if (exec_pending !== e) $display("FAIL reset_exec: got %h want %h", exec_pending, e); else n_pass++;
        n_chk++; if (m0_pending !== e) $display("FAIL reset_m0: got %h want %h", m0_pending, e); else n_pass++;
        n_chk++; if (scc_pending !== e) $display("FAIL reset_scc: got %h want %h", scc_pending, e); else n_pass++;
        n_chk++; if (issue_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", issue_ready); else n_pass++;
        n_chk++; if (dep_err !== 1'b0) $display("FAIL reset_err: got %b want 0", dep_err); else n_pass++;
    endtask

    task automatic test_accept();
        idle();
        issue_valid = 1'b1; issue_wfid = 6'd5; issue_wr_vcc = 1'b1; issue_wr_scc = 1'b1;
        #1;
        n_chk++; if (vcc_pending[5] !== 1'b0) $display("FAIL accept_latency: got %b want 0", vcc_pending[5]); else n_pass++;
        step();
        idle();
        e = '0; e[5] = 1'b1;
        n_chk++; if (vcc_pending !== e) $display("FAIL accept_vcc: got %h want %h", vcc_pending, e); else n_pass++;
        n_chk++; if (scc_pending !== e) $display("FAIL accept_scc: got %h want %h", scc_pending, e); else n_pass++;
        e = '0;
        n_chk++; if ((exec_pending | m0_pending) !== e) $display("FAIL accept_others: got %h want %h", exec_pending | m0_pending, e); else n_pass++;
        salu_wr_wfid = 6'd5; issue_salu_wr_scc_en = 1'b1;
        issue_valu_wr_vcc_en = 1'b1; issue_valu_wr_vcc_wfid = 6'd5;
        step();
        idle();
        n_chk++; if ((vcc_pending | scc_pending) !== e) $display("FAIL accept_retire: got %h want %h", vcc_pending | scc_pending, e); else n_pass++;
    endtask

    task automatic test_saturation();
        idle();
        issue_valid = 1'b1; issue_wfid = 6'd3; issue_wr_vcc = 1'b1;
        for (int i = 0; i < 7; i++) step();
        #1;
        n_chk++; if (issue_ready !== 1'b0) $display("FAIL sat_ready_full: got %b want 0", issue_ready); else n_pass++;
        issue_wfid = 6'd4; #1;
        n_chk++; if (issue_ready !== 1'b1) $display("FAIL sat_ready_other_wf: got %b want 1", issue_ready); else n_pass++;
        issue_wfid = 6'd3; issue_wr_vcc = 1'b0; issue_wr_exec = 1'b1; issue_valid = 1'b0; #1;
        n_chk++; if (issue_ready !== 1'b1) $display("FAIL sat_ready_non_vcc: got %b want 1", issue_ready); else n_pass++;
        // Offered but not accepted: counter must stay at 7.
        issue_wr_exec = 1'b0; issue_wr_vcc = 1'b1; issue_valid = 1'b1;
        step();
        idle();
        issue_valu_wr_vcc_en = 1'b1; issue_valu_wr_vcc_wfid = 6'd3;
        step();
        idle();
        issue_wfid = 6'd3; issue_wr_vcc = 1'b1; #1;
        n_chk++; if (issue_ready !== 1'b1) $display("FAIL sat_ready_after_retire: got %b want 1", issue_ready); else n_pass++;
        idle();
        salu_wr_wfid = 6'd3; issue_salu_wr_vcc_en = 1'b1;
        issue_valu_wr_vcc_en = 1'b1; issue_valu_wr_vcc_wfid = 6'd3;
        step(); step();
        n_chk++; if (vcc_pending[3] !== 1'b1) $display("FAIL sat_drain_partial: got %b want 1", vcc_pending[3]); else n_pass++;
        step();
        idle();
        e = '0;
        n_chk++; if (vcc_pending !== e) $display("FAIL sat_drain_done: got %h want %h", vcc_pending, e); else n_pass++;
    endtask

    task automatic test_net_delta();
        idle();
        issue_valid = 1'b1; issue_wfid = 6'd2; issue_wr_vcc = 1'b1; issue_wr_scc = 1'b1;
        step(); step();
        issue_wr_scc = 1'b0;
        issue_valu_wr_vcc_en = 1'b1; issue_valu_wr_vcc_wfid = 6'd2;
        salu_wr_wfid = 6'd2; issue_salu_wr_vcc_en = 1'b1;
        issue_wr_scc = 1'b1; issue_salu_wr_scc_en = 1'b1;
        step();
        idle();
        e = '0; e[2] = 1'b1;
        n_chk++; if (vcc_pending !== e) $display("FAIL net_vcc_2_to_1: got %h want %h", vcc_pending, e); else n_pass++;
        n_chk++; if (scc_pending !== e) $display("FAIL net_scc_set_wins: got %h want %h", scc_pending, e); else n_pass++;
        issue_valu_wr_vcc_en = 1'b1; issue_valu_wr_vcc_wfid = 6'd2;
        salu_wr_wfid = 6'd2; issue_salu_wr_scc_en = 1'b1;
        step();
        idle();
        e = '0;
        n_chk++; if ((vcc_pending | scc_pending) !== e) $display("FAIL net_final_clear: got %h want %h", vcc_pending | scc_pending, e); else n_pass++;
    endtask

    task automatic test_init();
        idle();
        issue_valid = 1'b1; issue_wfid = 6'd9; issue_wr_exec = 1'b1; issue_wr_vcc = 1'b1;
        step();
        e = '0; e[9] = 1'b1;
        n_chk++; if (exec_pending !== e) $display("FAIL init_exec_set: got %h want %h", exec_pending, e); else n_pass++;
        fetch_init_wf_en = 1'b1; fetch_init_wf_id = 6'd9;
        step();
        idle();
        e = '0;
        n_chk++; if (exec_pending !== e) $display("FAIL init_exec_priority: got %h want %h", exec_pending, e); else n_pass++;
        n_chk++; if (vcc_pending !== e) $display("FAIL init_vcc_priority: got %h want %h", vcc_pending, e); else n_pass++;
    endtask

    task automatic test_dep_err();
        do_reset();
        salu_wr_wfid = 6'd0; issue_salu_wr_m0_en = 1'b1;
        step();
        idle();
        n_chk++; if (dep_err !== exp_err) $display("FAIL err_m0_clear: got %b want %b", dep_err, exp_err); else n_pass++;
        step();
        n_chk++; if (dep_err !== exp_err) $display("FAIL err_sticky: got %b want %b", dep_err, exp_err); else n_pass++;
        e = '0;
        n_chk++; if (m0_pending !== e) $display("FAIL err_m0_stays_clear: got %h want %h", m0_pending, e); else n_pass++;
        do_reset();
        n_chk++; if (dep_err !== 1'b0) $display("FAIL err_cleared_by_rst: got %b want 0", dep_err); else n_pass++;
    endtask

    task automatic test_underflow_oob();
        do_reset();
        issue_valu_wr_vcc_en = 1'b1; issue_valu_wr_vcc_wfid = 6'd6;
        step();
        idle();
        e = '0;
        n_chk++; if (vcc_pending !== e) $display("FAIL under_zero: got %h want %h", vcc_pending, e); else n_pass++;
        issue_valid = 1'b1; issue_wfid = 6'd6; issue_wr_vcc = 1'b1;
        step();
        idle();
        issue_valu_wr_vcc_en = 1'b1; issue_valu_wr_vcc_wfid = 6'd6;
        salu_wr_wfid = 6'd6; issue_salu_wr_vcc_en = 1'b1;
        step();
        idle();
        n_chk++; if (vcc_pending !== e) $display("FAIL under_double_from_1: got %h want %h", vcc_pending, e); else n_pass++;
        issue_valid = 1'b1; issue_wfid = 6'd45;
        issue_wr_vcc = 1'b1; issue_wr_exec = 1'b1; issue_wr_m0 = 1'b1; issue_wr_scc = 1'b1;
        step();
        idle();
        n_chk++; if ((vcc_pending | exec_pending | m0_pending | scc_pending) !== e)
            $display("FAIL oob_issue_ignored: got %h want %h", vcc_pending | exec_pending | m0_pending | scc_pending, e);
        else n_pass++;
        n_chk++; if (dep_err !== exp_err) $display("FAIL oob_err: got %b want %b", dep_err, exp_err); else n_pass++;
        do_reset();
    endtask

    initial begin
`ifdef EXEC_DEP_TRACKER_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        idle();
        rst = 1'b1;
        step(); step();
        test_reset();
        test_accept();
        test_saturation();
        test_net_delta();
        test_init();
        test_dep_err();
        test_underflow_oob();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exec_dep_tracker.md
EXEC_DEP_TRACKER -- requirements
Module: exec_dep_tracker

Interface
REQ-001 SHALL have parameter NUM_WF, default 40, meaning the number of tracked wavefront slots.
REQ-002 SHALL have parameter VCC_CNT_W, default 3, meaning the width of each per-wavefront outstanding-VCC-write counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  issue offers an instruction.
- issue_ready  out  1  tracker accepts it.
- issue_wfid  in  6  wavefront of the offered instruction.
- issue_wr_vcc, issue_wr_exec, issue_wr_m0, issue_wr_scc  in  1 each  instruction will write that register.
- issue_valu  in  1  a VCC write comes from a VALU (1) or the SALU (0).
- salu_wr_wfid  in  6  SALU writeback wfid.
- issue_salu_wr_vcc_en, issue_salu_wr_exec_en, issue_salu_wr_m0_en, issue_salu_wr_scc_en  in  1 each  SALU retire strobes.
- issue_valu_wr_vcc_en  in  1  muxed VALU VCC retire strobe.
- issue_valu_wr_vcc_wfid  in  6  wfid of that strobe.
- fetch_init_wf_en  in  1  wavefront slot (re)initialised.
- fetch_init_wf_id  in  6  slot being initialised.
- vcc_pending, exec_pending, m0_pending, scc_pending  out  NUM_WF each  bit w = slot w has an outstanding write.
- dep_err  out  1  sticky protocol error.

Function
REQ-005 SHALL keep, per slot, a VCC_CNT_W-bit VCC counter plus 1-bit EXEC, M0 and SCC pending flags.
REQ-006 SHALL drive each pending output bit combinationally from its state: for VCC, counter != 0; for the others, the flag.
REQ-007 An issue SHALL be accepted on the cycle where issue_valid && issue_ready.
REQ-008 SHALL drive issue_ready low only when issue_wr_vcc=1 and the counter of issue_wfid equals 2^VCC_CNT_W-1.
REQ-009 SHALL deassert issue_ready only on counter saturation, never on EXEC/M0/SCC pending; issue applies its own stalls from the pending vectors.
REQ-010 On accept, SHALL increment the VCC counter if issue_wr_vcc=1, and SHALL set each other flag whose issue_wr_* is set.
REQ-011 Tracker state SHALL update on the next clock edge after accept or retire (one cycle latency to the pending outputs).
REQ-012 issue_salu_wr_vcc_en and issue_valu_wr_vcc_en SHALL each decrement the counter of their own wfid.
REQ-013 SHALL apply both decrements in the same cycle; when both name the same wfid, the counter SHALL drop by 2.
REQ-014 issue_salu_wr_exec_en, issue_salu_wr_m0_en and issue_salu_wr_scc_en SHALL clear the corresponding flag of salu_wr_wfid.
REQ-015 When an accept and a retire hit the same slot and register in one cycle, SHALL apply the net delta to the counter (e.g. +1 and -1 leave it unchanged).
REQ-016 When a set and a clear hit the same flag in one cycle, SHALL leave the flag set.
REQ-017 A decrement below 0 SHALL saturate at 0; a clear of an already-clear flag SHALL have no effect.
REQ-018 fetch_init_wf_en SHALL zero all four state items of fetch_init_wf_id and SHALL take priority over same-cycle accept and retire to that slot.
REQ-019 Any wfid >= NUM_WF on an active strobe SHALL be ignored; it SHALL cause no state change.

Reset
REQ-020 While rst=1 at a clock edge, all counters, flags and dep_err SHALL be cleared.
REQ-021 After rst, all pending outputs SHALL be 0 and issue_ready SHALL be 1.
REQ-022 rst SHALL override every same-cycle event.

Configuration
REQ-023 Macro EXEC_DEP_TRACKER_ERR_EN defined: dep_err SHALL set on any of the following and hold until rst:
- a decrement of a zero counter;
- a clear of a clear flag;
- an out-of-range wfid on an active strobe.
REQ-024 Macro EXEC_DEP_TRACKER_ERR_EN undefined: no error logic SHALL be built, and dep_err SHALL be tied to 0.

Structure
REQ-025 NUM_WF and the wfid width SHALL come from the shared global_definitions header.
REQ-026 The VCC counter width default SHALL come from issue_definitions.
REQ-027 SHALL instantiate one sub-module, dep_slot, NUM_WF times; each dep_slot holds one slot's counter and flags and takes set, clear and init strobes.

Verification
REQ-028 Reset then accept wfid 5 with wr_vcc=1 and wr_scc=1 -> next cycle vcc_pending[5]=1, scc_pending[5]=1, all other bits 0.
REQ-029 Accept 7 VCC writes on wfid 3 -> issue_ready=0 for an 8th vcc write on wfid 3, issue_ready=1 for wfid 4; one VALU retire on wfid 3 -> issue_ready returns to 1 the next cycle.
REQ-030 Same cycle: accept vcc on wfid 2, VALU retire on wfid 2, SALU vcc retire on wfid 2, with counter=2 -> counter=1 and vcc_pending[2]=1.
REQ-031 Set exec on wfid 9, then fetch_init_wf_id=9 in the same cycle as a new exec accept on wfid 9 -> exec_pending[9]=0.
REQ-032 Macro defined: SALU m0 clear on wfid 0 with flag clear -> dep_err=1 and held; then rst -> dep_err=0.
REQ-033 Macro undefined: the same stimulus as REQ-032 -> dep_err=0.
